// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: arbitrates the register file's single write port among three
// writeback sources (exe = ALU result, mem = load data, sys = interrupt/reset
// entry sequencer). The winning write is registered one cycle before the
// register file sees it. In-flight writes that alias a read port raise hit_x,
// so the decoder can stall.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   {exe,mem,sys}_valid/_ready    request / grant (transfer = valid & ready)
//   {exe,mem,sys}_addr/_data      destination register and write data
//   {exe,mem,sys}_word/_hi/_fl    word op, also write d[31:16] to DX, write flags
//   {exe,mem,sys}_flags           flag value
//   sys_lock                      keep exclusive ownership after this sys transfer
//   wr, wrhi, wrfl, word_op, addr_d, d, iflags   registered write port
//   rd_addr_{a,b,c}, rd_word      current read addresses and read width
//   hit_{a,b,c}                   in-flight write aliases that read
//   locked                        sys holds exclusive ownership
//
// Optional build macro ARB_PERF_EN adds exe/mem/sys_stall_cnt: 16-bit
// saturating counts of cycles where a source is valid but not granted.
module regfile_wr_arb #(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int FW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exe_valid,
  output logic          exe_ready,
  input  logic [AW-1:0] exe_addr,
  input  logic [DW-1:0] exe_data,
  input  logic          exe_word,
  input  logic          exe_hi,
  input  logic          exe_fl,
  input  logic [FW-1:0] exe_flags,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_word,
  input  logic          mem_hi,
  input  logic          mem_fl,
  input  logic [FW-1:0] mem_flags,
  input  logic          sys_valid,
  output logic          sys_ready,
  input  logic [AW-1:0] sys_addr,
  input  logic [DW-1:0] sys_data,
  input  logic          sys_word,
  input  logic          sys_hi,
  input  logic          sys_fl,
  input  logic [FW-1:0] sys_flags,
  input  logic          sys_lock,
  output logic          wr,
  output logic          wrhi,
  output logic          wrfl,
  output logic          word_op,
  output logic [AW-1:0] addr_d,
  output logic [DW-1:0] d,
  output logic [FW-1:0] iflags,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic [AW-1:0] rd_addr_c,
  input  logic          rd_word,
  output logic          hit_a,
  output logic          hit_b,
  output logic          hit_c,
  output logic          locked
`ifdef ARB_PERF_EN
 ,output logic [15:0]   exe_stall_cnt,
  output logic [15:0]   mem_stall_cnt,
  output logic [15:0]   sys_stall_cnt
`endif
);

  typedef enum logic { IDLE, LOCKED } state_e;
  typedef enum logic { RR_EXE, RR_MEM } rr_e;

  state_e state_q;
  rr_e    rr_q;

  logic          wr_q, wrhi_q, wrfl_q, word_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] d_q;
  logic [FW-1:0] flags_q;

  logic exe_fire, mem_fire, sys_fire;

  // Grant logic. A pointer-side source keeps ready while the other side is
  // idle, so an empty cycle still offers the tie-winner the port; the other
  // side only gets ready when it is valid and the pointer side is not.
  always_comb begin
    exe_ready = 1'b0;
    mem_ready = 1'b0;
    sys_ready = 1'b0;
    if (rst) begin
      if (state_q == LOCKED || sys_valid) begin
        sys_ready = 1'b1;
      end else if (rr_q == RR_EXE) begin
        exe_ready = exe_valid | ~mem_valid;
        mem_ready = ~exe_ready;
      end else begin
        mem_ready = mem_valid | ~exe_valid;
        exe_ready = ~mem_ready;
      end
    end
  end

  assign exe_fire = exe_valid & exe_ready;
  assign mem_fire = mem_valid & mem_ready;
  assign sys_fire = sys_valid & sys_ready;

  // FSM and round-robin pointer; sys grants leave the pointer alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= RR_EXE;
    end else begin
      if (sys_fire) state_q <= sys_lock ? LOCKED : IDLE;
      if (exe_fire)      rr_q <= RR_MEM;
      else if (mem_fire) rr_q <= RR_EXE;
    end
  end

  // Write stage: strobes pulse for one cycle, payload holds between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      wrhi_q  <= 1'b0;
      wrfl_q  <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      d_q     <= '0;
      flags_q <= '0;
    end else begin
      wr_q   <= exe_fire | mem_fire | sys_fire;
      wrhi_q <= 1'b0;
      wrfl_q <= 1'b0;
      if (sys_fire) begin
        wrhi_q <= sys_hi;   wrfl_q <= sys_fl;   word_q  <= sys_word;
        addr_q <= sys_addr; d_q    <= sys_data; flags_q <= sys_flags;
      end else if (exe_fire) begin
        wrhi_q <= exe_hi;   wrfl_q <= exe_fl;   word_q  <= exe_word;
        addr_q <= exe_addr; d_q    <= exe_data; flags_q <= exe_flags;
      end else if (mem_fire) begin
        wrhi_q <= mem_hi;   wrfl_q <= mem_fl;   word_q  <= mem_word;
        addr_q <= mem_addr; d_q    <= mem_data; flags_q <= mem_flags;
      end
    end
  end

  assign wr      = wr_q;
  assign wrhi    = wrhi_q;
  assign wrfl    = wrfl_q;
  assign word_op = word_q;
  assign addr_d  = addr_q;
  assign d       = d_q;
  assign iflags  = flags_q;
  assign locked  = (state_q == LOCKED);

  // Byte registers 4..7 (AH..BH) live in the upper half of words 0..3, so
  // they collapse onto the word index; everything else maps to itself.
  function automatic logic [AW-1:0] eidx(input logic [AW-1:0] a, input logic w);
    eidx = a;
    if (!w && a[3:2] == 2'b01) eidx[3:2] = 2'b00;
  endfunction

  logic [AW-1:0] widx;
  assign widx = eidx(addr_q, word_q);

  // wrhi also lands in DX (index 2), so it aliases that read independently.
  assign hit_a = (wr_q & (widx == eidx(rd_addr_a, rd_word)))
               | (wrhi_q & (eidx(rd_addr_a, rd_word) == AW'(2)));
  assign hit_b = (wr_q & (widx == eidx(rd_addr_b, rd_word)))
               | (wrhi_q & (eidx(rd_addr_b, rd_word) == AW'(2)));
  assign hit_c = (wr_q & (widx == eidx(rd_addr_c, rd_word)))
               | (wrhi_q & (eidx(rd_addr_c, rd_word) == AW'(2)));

`ifdef ARB_PERF_EN
  logic [15:0] exe_cnt_q, mem_cnt_q, sys_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_cnt_q <= '0;
      mem_cnt_q <= '0;
      sys_cnt_q <= '0;
    end else begin
      if (exe_valid && !exe_ready && exe_cnt_q != 16'hffff) exe_cnt_q <= exe_cnt_q + 16'd1;
      if (mem_valid && !mem_ready && mem_cnt_q != 16'hffff) mem_cnt_q <= mem_cnt_q + 16'd1;
      if (sys_valid && !sys_ready && sys_cnt_q != 16'hffff) sys_cnt_q <= sys_cnt_q + 16'd1;
    end
  end

  assign exe_stall_cnt = exe_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;
  assign sys_stall_cnt = sys_cnt_q;
`endif

endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Arbitrates the register file's single write port (wr/addr_d/d/word_op/wrhi/wrfl/iflags) among three writeback sources:
  - exe: ALU result
  - mem: load data
  - sys: interrupt/reset entry sequencer
- Registers the winning write one cycle before the register file sees it.
- Flags in-flight writes that alias the read ports, so the decoder can stall.

Parameters:
- DW, 32, data width of d (low 16 = word result, high 16 = wrhi payload)
- AW, 4, register address width
- FW, 9, flag vector width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- exe_valid / mem_valid / sys_valid  in  1  request valid, one per source
- exe_ready / mem_ready / sys_ready  out  1  grant; transfer occurs when valid&ready
- {exe,mem,sys}_addr  in  AW  destination register
- {exe,mem,sys}_data  in  DW  write data
- {exe,mem,sys}_word  in  1  1 = word op, 0 = byte op
- {exe,mem,sys}_hi  in  1  also write d[31:16] to r2 (DX)
- {exe,mem,sys}_fl  in  1  write flags
- {exe,mem,sys}_flags  in  FW  flag value
- sys_lock  in  1  keep exclusive ownership after this transfer
- wr, wrhi, wrfl, word_op  out  1  registered strobes to register file
- addr_d  out  AW  registered
- d  out  DW  registered
- iflags  out  FW  registered
- rd_addr_a, rd_addr_b, rd_addr_c  in  AW  current read addresses
- rd_word  in  1  read width, applies to a/b/c
- hit_a, hit_b, hit_c  out  1  in-flight write aliases that read
- locked  out  1  FSM in LOCKED

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; rr pointer = exe; FSM = IDLE.
  - Any transfer granted in the reset cycle is discarded.
- FSM states: IDLE, LOCKED.
- IDLE priority:
  - sys > round-robin(exe, mem).
  - rr pointer flips only when exe or mem completes a transfer.
  - On a tie, the source at the pointer wins.
- ready is combinational from the valids, the pointer and the FSM state:
  - At most one ready is high per cycle.
  - ready never depends on its own valid being low.
- IDLE -> LOCKED: a sys transfer completes with sys_lock=1.
- LOCKED:
  - exe_ready = mem_ready = 0.
  - sys_ready = 1.
  - LOCKED -> IDLE when a sys transfer completes with sys_lock=0.
  - sys_valid=0 in LOCKED simply holds.
- Latency: a transfer in cycle N puts its registered fields on the outputs in cycle N+1.
  - wr = 1 for exactly that one cycle.
  - wrhi/wrfl = source's hi/fl bits.
  - No transfer -> wr=wrhi=wrfl=0; addr_d/d/word_op/iflags hold their previous values.
  - Throughput: one write per cycle.
- Alias mapping, effective word index:
  - Write: word or addr[3]=1 -> addr; byte with addr[3:2]=01 -> {00,addr[1:0]}; byte with addr[3:2]=00 -> addr.
  - Read: same mapping, using rd_word.
- hit_x = wr & (idx(addr_d) == idx(rd_addr_x)), OR'ed with wrhi & (idx(rd_addr_x) == 2).
- hit_x is combinational from the registered stage.
- Simultaneous events:
  - A sys request arriving while exe and mem both wait wins immediately.
  - The rr pointer is unchanged by sys grants.

Optional Feature:
- Macro: ARB_PERF_EN.
- When defined, adds three outputs: exe_stall_cnt, mem_stall_cnt, sys_stall_cnt, each 16 bits.
  - Each is a saturating counter (sticks at 16'hffff) incremented in cycles where that source has valid=1 and ready=0.
  - Counters clear on reset.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset mid-flight: exe transfer at N, rst low during N+1 -> wr drops to 0 immediately; after release, outputs are 0 and the first tie grants exe.
- exe and mem valid continuously, sys idle:
  - Grants alternate exe, mem, exe, mem.
  - wr=1 every cycle from the second cycle on, with addr_d alternating exe_addr=3 and mem_addr=6.
- Lock sequence:
  - sys writes addr 9 data 0x0000f000 with lock=1, then addr 15 data 0x0000fff0 with lock=0; exe valid throughout.
  - exe_ready=0 for both cycles and locked=1 between them; exe is granted the cycle after the second sys write.
- Byte aliasing:
  - mem writes addr 4 (AH), word=0 -> next cycle hit_a=1 for rd_addr_a=0 (rd_word=1).
  - hit_a=1 for rd_addr_a=4 (rd_word=0); hit_a=0 for rd_addr_a=8.
- wrhi: exe addr 0, hi=1, data 0x1234abcd -> next cycle wr=wrhi=1, d=0x1234abcd, hit_b=1 for rd_addr_b=2.
- ARB_PERF_EN: exe held valid for 5 cycles while sys locked -> exe_stall_cnt=5; forced 70000 stalls -> 0xffff.
